// File: rtl/bcd_digit_counter_de2.sv
// Single-digit BCD up/down counter feeding the HEX0 seven-segment decoder.
// Counts on a prescaled tick or a debounced pushbutton step, loads from switches, pulses CARRY on wrap.
module bcd_digit_counter_de2 #(
    parameter int CLK_HZ          = 50000000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       EN,
    input  logic       UP_DOWN,
    input  logic       LOAD,
    input  logic [3:0] LOAD_VAL,
    input  logic       STEP_N,
    output logic [3:0] DIGIT,
    output logic       CARRY,
    output logic       TICK
);

    localparam int              DIV     = CLK_HZ / TICK_HZ;
    localparam int              PS_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);
    localparam int               DBC_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBC_W-1:0] DBC_PRE = DBC_W'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } dbs_t;

    // Out-of-range switch values collapse to 0 so DIGIT never leaves 0..9.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
        return (v <= 4'd9) ? v : 4'd0;
    endfunction

    logic             sync1_q;
    logic             sync_n_q;
    dbs_t             dbs_q;
    logic [DBC_W-1:0] dbc_q;
    logic             step_pulse_q;
    logic [PS_W-1:0]  ps_q;
    logic [PS_W-1:0]  ps_d;
    logic [3:0]       digit_q;
    logic [3:0]       digit_d;
    logic             carry_q;
    logic             carry_d;
    logic             tick;
    logic             evt;

    // Stage 0: two-flop synchronizer, idles high like the released button.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1_q  <= 1'b1;
            sync_n_q <= 1'b1;
        end else begin
            sync1_q  <= STEP_N;
            sync_n_q <= sync1_q;
        end
    end

    // Stage 1: debouncer; step_pulse_q fires only on the accepted press edge.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            dbs_q        <= RELEASED;
            dbc_q        <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            step_pulse_q <= 1'b0;
            case (dbs_q)
                RELEASED: begin
                    if (!sync_n_q) begin
                        dbc_q <= '0;
                        dbs_q <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (sync_n_q) begin
                        dbs_q <= RELEASED;
                    end else begin
                        dbc_q <= dbc_q + 1'b1;
                        if (dbc_q == DBC_PRE) begin
                            dbs_q        <= PRESSED;
                            step_pulse_q <= 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (sync_n_q) begin
                        dbc_q <= '0;
                        dbs_q <= RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (!sync_n_q) begin
                        dbs_q <= PRESSED;
                    end else begin
                        dbc_q <= dbc_q + 1'b1;
                        if (dbc_q == DBC_PRE) begin
                            dbs_q <= RELEASED;
                        end
                    end
                end
                default: dbs_q <= RELEASED;
            endcase
        end
    end

    always_comb begin
        tick = EN && (ps_q == PS_LAST);
        evt  = tick || step_pulse_q;

        ps_d = ps_q;
        if (LOAD) begin
            ps_d = '0;
        end else if (EN) begin
            ps_d = tick ? '0 : ps_q + 1'b1;
        end

        digit_d = digit_q;
        carry_d = 1'b0;
        if (LOAD) begin
            digit_d = clamp_bcd(LOAD_VAL);
        end else if (evt) begin
            if (UP_DOWN) begin
                if (digit_q == 4'd9) begin
                    digit_d = 4'd0;
                    carry_d = 1'b1;
                end else begin
                    digit_d = digit_q + 4'd1;
                end
            end else begin
                if (digit_q == 4'd0) begin
                    digit_d = 4'd9;
                    carry_d = 1'b1;
                end else begin
                    digit_d = digit_q - 4'd1;
                end
            end
        end
    end

    // Stage 2: prescaler and digit registers.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            ps_q    <= '0;
            digit_q <= 4'd0;
            carry_q <= 1'b0;
        end else begin
            ps_q    <= ps_d;
            digit_q <= digit_d;
            carry_q <= carry_d;
        end
    end

    assign DIGIT = digit_q;
    assign CARRY = carry_q;
    assign TICK  = tick;

endmodule

// File: tb/tb_bcd_digit_counter_de2.sv
// Bench for bcd_digit_counter_de2: directed vector table, counting sweep and randomized model comparison.
module tb_bcd_digit_counter_de2;

    localparam int CLK_HZ  = 10;
    localparam int TICK_HZ = 1;
    localparam int DEB     = 4;
    localparam int PS_LAST = CLK_HZ / TICK_HZ - 1;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic       EN       = 1'b0;
    logic       UP_DOWN  = 1'b1;
    logic       LOAD     = 1'b0;
    logic [3:0] LOAD_VAL = 4'd0;
    logic       STEP_N   = 1'b1;
    logic [3:0] DIGIT;
    logic       CARRY;
    logic       TICK;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_digit_counter_de2 #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .EN(EN), .UP_DOWN(UP_DOWN),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .STEP_N(STEP_N),
        .DIGIT(DIGIT), .CARRY(CARRY), .TICK(TICK)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int         rep;
        bit         rst, en, ud, load;
        logic [3:0] lv;
        bit         stepn;
        int         d;
        bit         c;
        bit         ct;
        bit         t;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int rep, bit rst, bit en, bit ud, bit load, int lv,
                                bit stepn, int d, bit c, bit ct, bit t);
        vec_t r;
        r.rep = rep; r.rst = rst; r.en = en; r.ud = ud; r.load = load;
        r.lv = 4'(lv); r.stepn = stepn; r.d = d; r.c = c; r.ct = ct; r.t = t;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Each repetition: TICK checked before the edge, DIGIT/CARRY just after it.
    task automatic apply(input vec_t r, input int idx);
        RESET = r.rst; EN = r.en; UP_DOWN = r.ud; LOAD = r.load;
        LOAD_VAL = r.lv; STEP_N = r.stepn;
        for (int k = 0; k < r.rep; k++) begin
            #2;
            if (r.ct) chk($sformatf("row%0d.%0d TICK", idx, k), 32'(TICK), 32'(r.t));
            @(posedge CLOCK_50);
            #1;
            chk($sformatf("row%0d.%0d DIGIT", idx, k), 32'(DIGIT), 32'(r.d));
            chk($sformatf("row%0d.%0d CARRY", idx, k), 32'(CARRY), 32'(r.c));
        end
    endtask

    // Reference model state for the randomized phase.
    int m_ps, m_d, m_st, m_dbc;
    bit m_c, m_s1, m_s2, m_step;

    task automatic m_edge();
        bit tk, evt, nstep;
        if (RESET) begin
            m_ps = 0; m_d = 0; m_c = 0; m_s1 = 1; m_s2 = 1;
            m_st = 0; m_dbc = 0; m_step = 0;
        end else begin
            tk    = EN && (m_ps == PS_LAST);
            evt   = tk || m_step;
            nstep = 0;
            case (m_st)
                0: if (!m_s2) begin m_dbc = 0; m_st = 1; end
                1: if (m_s2) m_st = 0;
                   else begin
                       m_dbc++;
                       if (m_dbc == DEB - 1) begin m_st = 2; nstep = 1; end
                   end
                2: if (m_s2) begin m_dbc = 0; m_st = 3; end
                default: if (!m_s2) m_st = 2;
                   else begin
                       m_dbc++;
                       if (m_dbc == DEB - 1) m_st = 0;
                   end
            endcase
            m_step = nstep;
            m_s2 = m_s1;
            m_s1 = STEP_N;
            if (LOAD) m_ps = 0;
            else if (EN) m_ps = tk ? 0 : m_ps + 1;
            m_c = 0;
            if (LOAD) m_d = (LOAD_VAL <= 9) ? int'(LOAD_VAL) : 0;
            else if (evt) begin
                if (UP_DOWN) begin m_c = (m_d == 9); m_d = (m_d + 1) % 10; end
                else begin m_c = (m_d == 0); m_d = (m_d + 9) % 10; end
            end
        end
    endtask

    initial begin
        int hold;

        // Counting sweep: reset, then 100 cycles of up-count on ticks.
        apply(mk(2, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0), 0);
        RESET = 0; EN = 1; UP_DOWN = 1;
        for (int i = 0; i < 100; i++) begin
            #2;
            chk($sformatf("sweep%0d TICK", i), 32'(TICK), 32'((i % 10) == 9));
            @(posedge CLOCK_50);
            #1;
            chk($sformatf("sweep%0d DIGIT", i), 32'(DIGIT), 32'(((i + 1) / 10) % 10));
            chk($sformatf("sweep%0d CARRY", i), 32'(CARRY), 32'(i == 99));
        end

        //          rep rst en ud ld lv sn  d  c ct t
        // down-count wrap from load 0, load clamping
        tbl.push_back(mk(2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(9, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 9, 1, 1, 1));
        tbl.push_back(mk(9, 0, 1, 0, 0, 0, 1, 9, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 8, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 12, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 9, 1, 9, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 10, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 15, 1, 0, 0, 1, 0));
        // load coincident with tick wins and restarts the prescaler
        tbl.push_back(mk(1, 0, 0, 1, 1, 4, 1, 4, 0, 1, 0));
        tbl.push_back(mk(9, 0, 1, 1, 0, 0, 1, 4, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 7, 1, 7, 0, 1, 1));
        tbl.push_back(mk(9, 0, 1, 1, 0, 0, 1, 7, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 1, 8, 0, 1, 1));
        // load on a wrapping tick suppresses CARRY
        tbl.push_back(mk(1, 0, 0, 1, 1, 9, 1, 9, 0, 1, 0));
        tbl.push_back(mk(9, 0, 1, 1, 0, 0, 1, 9, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 3, 1, 3, 0, 1, 1));
        // EN low freezes the prescaler, even at terminal count
        tbl.push_back(mk(5, 0, 1, 1, 0, 0, 1, 3, 0, 1, 0));
        tbl.push_back(mk(20, 0, 0, 1, 0, 0, 1, 3, 0, 1, 0));
        tbl.push_back(mk(4, 0, 1, 1, 0, 0, 1, 3, 0, 1, 0));
        tbl.push_back(mk(3, 0, 0, 1, 0, 0, 1, 3, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 2, 0, 1, 1));
        // step pulse coincident with tick at DIGIT=4 counts once
        tbl.push_back(mk(1, 0, 0, 1, 1, 4, 1, 4, 0, 1, 0));
        tbl.push_back(mk(3, 0, 1, 1, 0, 0, 1, 4, 0, 1, 0));
        tbl.push_back(mk(6, 0, 1, 1, 0, 0, 0, 4, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 5, 0, 1, 1));
        tbl.push_back(mk(10, 0, 0, 1, 0, 0, 0, 5, 0, 1, 0));
        tbl.push_back(mk(10, 0, 0, 1, 0, 0, 1, 5, 0, 1, 0));
        // bouncy press: short lows rejected, stable low accepted once
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 5, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 5, 0, 1, 0));
        tbl.push_back(mk(2, 0, 0, 1, 0, 0, 0, 5, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 5, 0, 1, 0));
        tbl.push_back(mk(3, 0, 0, 1, 0, 0, 0, 5, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 5, 0, 1, 0));
        tbl.push_back(mk(6, 0, 0, 1, 0, 0, 0, 5, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 6, 0, 1, 0));
        tbl.push_back(mk(3, 0, 0, 1, 0, 0, 0, 6, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 6, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 6, 0, 1, 0));
        tbl.push_back(mk(2, 0, 0, 1, 0, 0, 1, 6, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 6, 0, 1, 0));
        tbl.push_back(mk(10, 0, 0, 1, 0, 0, 1, 6, 0, 1, 0));
        // reset mid-debounce, button held through reset release
        tbl.push_back(mk(4, 0, 0, 1, 0, 0, 0, 6, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(6, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(5, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(10, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i + 1);

        // Randomized run against the reference model.
        RESET = 1; EN = 0; LOAD = 0; STEP_N = 1;
        @(posedge CLOCK_50);
        m_edge();
        #1;
        hold = 1;
        for (int i = 0; i < 10000; i++) begin
            RESET    = ($urandom_range(0, 499) == 0);
            EN       = ($urandom_range(0, 3) != 0);
            UP_DOWN  = 1'($urandom_range(0, 1));
            LOAD     = ($urandom_range(0, 15) == 0);
            LOAD_VAL = 4'($urandom_range(0, 15));
            hold--;
            if (hold == 0) begin
                STEP_N = ~STEP_N;
                hold   = $urandom_range(1, 8);
            end
            #2;
            chk($sformatf("rand%0d TICK", i), 32'(TICK), 32'(EN && (m_ps == PS_LAST)));
            @(posedge CLOCK_50);
            m_edge();
            #1;
            chk($sformatf("rand%0d DIGIT", i), 32'(DIGIT), 32'(m_d));
            chk($sformatf("rand%0d CARRY", i), 32'(CARRY), 32'(m_c));
            chk($sformatf("rand%0d RANGE", i), 32'(DIGIT <= 4'd9), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_digit_counter_de2.md
Name: bcd_digit_counter_de2

Overview:
- Single-digit BCD up/down counter that sits directly upstream of the binary-to-7-segment decoder on the DE2 board.
- Its DIGIT output drives the decoder's 4-bit input, which lights HEX0.
- The count advances on a prescaled timebase tick while running, or on a debounced pushbutton step.
- Supports synchronous load from switches and produces a wrap (carry/borrow) pulse for cascading further digits.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1, auto-count rate in Hz; prescaler terminal count = CLK_HZ/TICK_HZ - 1; CLK_HZ/TICK_HZ >= 2.
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles required to accept a button level change (20 ms at 50 MHz); >= 2.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- RESET  in  1  reset, synchronous, active-high.
- EN  in  1  run enable; 1 = count on prescaler ticks.
- UP_DOWN  in  1  count direction; 1 = up, 0 = down.
- LOAD  in  1  synchronous load strobe (level-sampled each cycle).
- LOAD_VAL  in  4  value loaded into DIGIT when LOAD = 1.
- STEP_N  in  1  raw pushbutton, active-low, asynchronous to CLOCK_50.
- DIGIT  out  4  registered BCD count, always in range 0..9.
- CARRY  out  1  one-cycle pulse on wrap: 9->0 when counting up, 0->9 when counting down.
- TICK  out  1  one-cycle prescaler tick, exposed for debug and cascading.

Behaviour:
- Reset (RESET = 1 at a clock edge):
  - DIGIT = 0, CARRY = 0, TICK = 0, prescaler = 0.
  - Synchronizer flops = 1; debouncer state = RELEASED; debounce counter = 0.
  - Reset mid-operation aborts any debounce in progress and any pending step; no step pulse is generated by the reset itself.
- STEP_N synchronization:
  - Two-flop synchronizer; only the second flop's output (sync_n) is used downstream.
- Debouncer FSM, with a counter dbc:
  - RELEASED: if sync_n = 0, clear dbc and go to PRESS_WAIT.
  - PRESS_WAIT: if sync_n = 1, go to RELEASED. Otherwise increment dbc; when dbc reaches DEBOUNCE_CYCLES-1, go to PRESSED and emit step_pulse for exactly one cycle.
  - PRESSED: if sync_n = 1, clear dbc and go to RELEASE_WAIT.
  - RELEASE_WAIT: if sync_n = 0, go to PRESSED. Otherwise increment dbc; at DEBOUNCE_CYCLES-1, go to RELEASED.
  - One accepted press produces exactly one step, no matter how long the button is held. Bounces shorter than DEBOUNCE_CYCLES produce none.
  - A button held low through reset release is accepted as a press after DEBOUNCE_CYCLES stable cycles.
- Prescaler:
  - While EN = 1: increments each cycle; at the terminal count it wraps to 0 and TICK is 1 for that cycle.
  - While EN = 0: holds its value; TICK = 0.
  - LOAD clears the prescaler to 0.
- Count event:
  - evt = TICK | step_pulse. Coincident TICK and step_pulse give a single step, not two.
  - step_pulse is honoured regardless of EN.
- Priority per cycle: RESET > LOAD > evt.
  - LOAD: DIGIT = LOAD_VAL if LOAD_VAL <= 9, else DIGIT = 0. CARRY = 0. Any coincident evt is discarded.
  - evt with UP_DOWN = 1: DIGIT = (DIGIT == 9) ? 0 : DIGIT+1; CARRY = 1 on the 9->0 transition.
  - evt with UP_DOWN = 0: DIGIT = (DIGIT == 0) ? 9 : DIGIT-1; CARRY = 1 on the 0->9 transition.
- Timing:
  - CARRY is registered and high in the same cycle DIGIT first shows the wrapped value; it is 0 in all other cycles.
  - DIGIT latency is 1 clock from evt or LOAD.
  - Button-to-DIGIT latency is 2 (synchronizer) + DEBOUNCE_CYCLES + 1 clocks.
- UP_DOWN and EN are sampled each cycle; no internal latching.
- DIGIT never leaves 0..9, so the downstream decoder's default branch is unreachable in normal operation.

Test Plan:
Bench parameters: CLK_HZ = 10, TICK_HZ = 1, DEBOUNCE_CYCLES = 4.
1. Reset, then EN = 1, UP_DOWN = 1 for 100 cycles -> TICK every 10th cycle; DIGIT steps 0,1,...,9,0; CARRY high exactly once, in the cycle DIGIT = 0 after 9.
2. LOAD = 1 with LOAD_VAL = 0, then EN = 1, UP_DOWN = 0 -> first tick gives DIGIT = 9 with CARRY = 1; next tick gives 8 with CARRY = 0. Separately, LOAD_VAL = 12 -> DIGIT = 0.
3. EN = 0; STEP_N low with bounces of 1-3 cycles, then stable low for 10 cycles, then bouncy high -> exactly one increment, 2 + 4 + 1 cycles after the stable-low start; no further steps during hold or release.
4. EN = 1; step_pulse forced to coincide with TICK at DIGIT = 4 -> DIGIT = 5, not 6. In another cycle, LOAD = 1 (LOAD_VAL = 7) coincident with TICK -> DIGIT = 7 and the prescaler restarts from 0.
5. DIGIT = 6 with STEP_N held low in PRESS_WAIT; assert RESET for 1 cycle mid-debounce -> DIGIT = 0, CARRY = 0, no step. Keep STEP_N low -> a single step to 1 after DEBOUNCE_CYCLES.
6. Random EN / UP_DOWN / LOAD / STEP_N for 10k cycles, checked against a reference model -> DIGIT always <= 9, CARRY only coincides with wrap transitions.
